// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS writeback stage: syscall codes, ABI register
// indices and the syscall unit state encoding.
package mips_pkg;

  localparam logic [31:0] SYS_HALT      = 32'd10;
  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_PRINT_HEX = 32'd34;

  localparam logic [4:0] REG_V0 = 5'd2;
  localparam logic [4:0] REG_A0 = 5'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/syscall_ctrl.sv
// Syscall unit: RUN/HALT state machine, display register and saturating
// syscall counter. Operates on already-bypassed $v0/$a0 values.
module syscall_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             syscall,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             resume,
  output logic             halt,
  output logic [31:0]      disp,
  output logic             disp_vld,
  output logic [CNT_W-1:0] sys_cnt,
  output logic             run
);

  wb_state_t        state_q, state_d;
  logic [31:0]      disp_q, disp_d;
  logic             disp_vld_q, disp_vld_d;
  logic [CNT_W-1:0] sys_cnt_q, sys_cnt_d;

  // Next-state logic: syscalls only act in RUN; HALT waits for resume and
  // drops any syscall that arrives alongside it.
  always_comb begin
    state_d    = state_q;
    disp_d     = disp_q;
    disp_vld_d = 1'b0;
    sys_cnt_d  = sys_cnt_q;
    case (state_q)
      RUN: begin
        if (syscall) begin
          if (sys_cnt_q != {CNT_W{1'b1}}) begin
            sys_cnt_d = sys_cnt_q + 1'b1;
          end
          if (v0 == SYS_HALT) begin
            state_d = HALT;
          end else if (v0 == SYS_PRINT_INT || v0 == SYS_PRINT_HEX) begin
            disp_d     = a0;
            disp_vld_d = 1'b1;
          end
        end
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, display and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      disp_q     <= '0;
      disp_vld_q <= 1'b0;
      sys_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      disp_q     <= disp_d;
      disp_vld_q <= disp_vld_d;
      sys_cnt_q  <= sys_cnt_d;
    end
  end

  assign run      = (state_q == RUN);
  assign halt     = (state_q == HALT);
  assign disp     = disp_q;
  assign disp_vld = disp_vld_q;
  assign sys_cnt  = sys_cnt_q;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: 32x32 architectural register file with same-cycle write
// bypass on both read ports, plus the syscall unit fed from bypassed $v0/$a0.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             syscall,
  input  logic             WE,
  input  logic [4:0]       RW,
  input  logic [31:0]      w,
  input  logic             resume,
  input  logic [4:0]       R1,
  input  logic [4:0]       R2,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic             halt,
  output logic [31:0]      disp,
  output logic             disp_vld,
  output logic [CNT_W-1:0] sys_cnt
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        run;
  logic        wr_en;
  logic [31:0] v0_byp;
  logic [31:0] a0_byp;

  assign wr_en = WE && (RW != 5'd0) && run;

  // Read one register as the ID stage sees it this cycle: a pending write to
  // the same index wins, and $0 is hard-wired to zero.
  function automatic logic [31:0] read_port(input logic [4:0] idx);
    if (wr_en && (RW == idx)) begin
      return w;
    end else if (idx == 5'd0) begin
      return 32'd0;
    end else begin
      return regs_q[idx];
    end
  endfunction

  // Bypassed read ports and syscall operands.
  always_comb begin
    A      = read_port(R1);
    B      = read_port(R2);
    v0_byp = read_port(REG_V0);
    a0_byp = read_port(REG_A0);
  end

  // Array next-state: only a gated write in RUN changes an entry.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[RW] = w;
    end
  end

  // Register array storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  syscall_ctrl #(
    .CNT_W(CNT_W)
  ) u_syscall_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .syscall  (syscall),
    .v0       (v0_byp),
    .a0       (a0_byp),
    .resume   (resume),
    .halt     (halt),
    .disp     (disp),
    .disp_vld (disp_vld),
    .sys_cnt  (sys_cnt),
    .run      (run)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by random
// traffic, all compared against an array-based reference model. A second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        syscall;
  logic        WE;
  logic [4:0]  RW;
  logic [31:0] w;
  logic        resume;
  logic [4:0]  R1;
  logic [4:0]  R2;
  logic [31:0] A, B, disp;
  logic        halt, disp_vld;
  logic [15:0] sys_cnt;
  logic [31:0] a2, b2, disp2;
  logic        halt2, dispVld2;
  logic [1:0]  sysCnt2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mRegs [32];
  logic [31:0] view  [32];
  bit          mHalted;
  logic [31:0] mDisp;
  bit          mVld;
  int          mCnt16;
  int          mCnt2;

  wb_regfile #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .syscall(syscall), .WE(WE), .RW(RW), .w(w),
    .resume(resume), .R1(R1), .R2(R2), .A(A), .B(B), .halt(halt),
    .disp(disp), .disp_vld(disp_vld), .sys_cnt(sys_cnt)
  );

  wb_regfile #(.CNT_W(2)) dutSmall (
    .clk(clk), .rst_n(rst_n), .syscall(syscall), .WE(WE), .RW(RW), .w(w),
    .resume(resume), .R1(R1), .R2(R2), .A(a2), .B(b2), .halt(halt2),
    .disp(disp2), .disp_vld(dispVld2), .sys_cnt(sysCnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mHalted = 0;
    mDisp   = 32'd0;
    mVld    = 0;
    mCnt16  = 0;
    mCnt2   = 0;
  endtask

  task automatic checkRegistered();
    checkOutput("halt", {31'd0, halt}, {31'd0, mHalted});
    checkOutput("disp", disp, mDisp);
    checkOutput("disp_vld", {31'd0, disp_vld}, {31'd0, mVld});
    checkOutput("sys_cnt", {16'd0, sys_cnt}, mCnt16);
    checkOutput("halt_small", {31'd0, halt2}, {31'd0, mHalted});
    checkOutput("sys_cnt_small", {30'd0, sysCnt2}, mCnt2);
  endtask

  // Drive one cycle starting just after a rising edge; check reads mid-cycle
  // and registered outputs just after the next rising edge.
  task automatic applyStimulus(input bit we, input logic [4:0] rw, input logic [31:0] wd,
                               input bit sc, input bit res, input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] v0, a0;
    WE = we; RW = rw; w = wd; syscall = sc; resume = res; R1 = r1; R2 = r2;
    #3;
    for (int i = 0; i < 32; i++) view[i] = mRegs[i];
    if (we && !mHalted && rw != 5'd0) view[rw] = wd;
    checkOutput("readA", A, view[r1]);
    checkOutput("readB", B, view[r2]);
    checkOutput("readA_small", a2, view[r1]);
    @(posedge clk);
    v0 = view[2];
    a0 = view[4];
    mVld = 0;
    if (!mHalted) begin
      if (sc) begin
        mCnt16 = (mCnt16 < 65535) ? mCnt16 + 1 : 65535;
        mCnt2  = (mCnt2 < 3) ? mCnt2 + 1 : 3;
        if (v0 == 32'd10) begin
          mHalted = 1;
        end else if (v0 == 32'd1 || v0 == 32'd34) begin
          mDisp = a0;
          mVld  = 1;
        end
      end
    end else if (res) begin
      mHalted = 0;
    end
    for (int i = 0; i < 32; i++) mRegs[i] = view[i];
    #1;
    checkRegistered();
  endtask

  initial begin
    rst_n = 1'b0; WE = 0; RW = 0; w = 0; syscall = 0; resume = 0; R1 = 0; R2 = 0;
    modelReset();
    #2;
    checkRegistered();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Bypass then array read
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd5);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 5'd5, 5'd0);
    // $0 stays zero
    applyStimulus(1, 5'd0, 32'h1234, 0, 0, 5'd0, 5'd0);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 5'd0, 5'd0);
    // Display syscall
    applyStimulus(1, 5'd2, 32'd34, 0, 0, 5'd2, 5'd4);
    applyStimulus(1, 5'd4, 32'h00C0FFEE, 0, 0, 5'd2, 5'd4);
    applyStimulus(0, 5'd0, 32'd0, 1, 0, 5'd2, 5'd4);
    checkOutput("plan_disp", disp, 32'h00C0FFEE);
    checkOutput("plan_vld", {31'd0, disp_vld}, 32'd1);
    checkOutput("plan_cnt", {16'd0, sys_cnt}, 32'd1);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 5'd0, 5'd0);
    checkOutput("plan_vld_drop", {31'd0, disp_vld}, 32'd0);
    // Halt via bypassed $v0
    applyStimulus(1, 5'd2, 32'd10, 1, 0, 5'd2, 5'd0);
    checkOutput("plan_halt", {31'd0, halt}, 32'd1);
    applyStimulus(1, 5'd7, 32'd5, 1, 0, 5'd7, 5'd0);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 5'd7, 5'd0);
    checkOutput("plan_cnt_hold", {16'd0, sys_cnt}, 32'd2);
    applyStimulus(0, 5'd0, 32'd0, 0, 1, 5'd7, 5'd0);
    checkOutput("plan_resume", {31'd0, halt}, 32'd0);
    applyStimulus(1, 5'd7, 32'd5, 0, 0, 5'd7, 5'd0);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 5'd7, 5'd0);
    // Reset mid-halt
    applyStimulus(1, 5'd9, 32'hAA, 0, 0, 5'd9, 5'd0);
    applyStimulus(1, 5'd2, 32'd10, 1, 0, 5'd9, 5'd0);
    WE = 0; syscall = 0; R1 = 5'd9;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_halt", {31'd0, halt}, 32'd0);
    checkOutput("rst_disp", disp, 32'd0);
    checkOutput("rst_cnt", {16'd0, sys_cnt}, 32'd0);
    checkOutput("rst_r9", A, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // Small counter saturation with $v0 = 0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 5'd0, 32'd0, 1, 0, 5'd2, 5'd0);
      checkOutput("cnt2_seq", {30'd0, sysCnt2}, (i < 3) ? i + 1 : 3);
    end
    // Random traffic biased toward syscall-relevant registers and codes
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  rw, r1, r2;
      logic [31:0] wd;
      case ($urandom_range(3))
        0: rw = 5'd2;
        1: rw = 5'd4;
        2: rw = 5'd0;
        default: rw = 5'($urandom);
      endcase
      case ($urandom_range(4))
        0: wd = 32'd1;
        1: wd = 32'd10;
        2: wd = 32'd34;
        3: wd = 32'd0;
        default: wd = $urandom;
      endcase
      r1 = ($urandom_range(1) == 0) ? rw : 5'($urandom);
      r2 = 5'($urandom);
      applyStimulus($urandom_range(1) == 1, rw, wd, $urandom_range(3) == 0,
                    $urandom_range(5) == 0, r1, r2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
